// File: rtl/uart_rx_if.sv
// Consumer-side handshake bundle for uart_rx_core.
//   rx_data     : last received character
//   rx_valid    : character pending until acknowledged
//   rx_ack      : consumer has taken rx_data
//   parity_err  : parity mismatch on the character in rx_data
//   framing_err : a stop bit voted 0 on the character in rx_data
//   overrun_err : previous character was overwritten before it was acknowledged
// master = receiver side, slave = consumer side.
interface uart_rx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ack;
  logic                 parity_err;
  logic                 framing_err;
  logic                 overrun_err;

  modport master (
    output rx_data, rx_valid, parity_err, framing_err, overrun_err,
    input  rx_ack
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, framing_err, overrun_err,
    output rx_ack
  );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: baud-tick divider, phase/bit counters, 3-sample majority vote,
// optional parity, 1 or 2 stop bits, error flags and a valid/ack handshake.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   enable  : receiver enable; low aborts any frame and holds the FSM idle
//   rx_in   : asynchronous serial line, idle high
//   rx_bus  : handshake/data/error bundle (master side)
//   busy    : FSM is not idle
module uart_rx_core #(
  parameter int unsigned CLK_DIV     = 326,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      enable,
  input  logic      rx_in,
  uart_rx_if.master rx_bus,
  output logic      busy
);

  localparam int unsigned DivW = $clog2(CLK_DIV + 2);
  localparam int unsigned PhW  = $clog2(OVERSAMPLE);
  localparam int unsigned BitW = $clog2(DATA_BITS);

  localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV);
  localparam logic [PhW-1:0]  PhMidM1  = PhW'(OVERSAMPLE / 2 - 1);
  localparam logic [PhW-1:0]  PhMid    = PhW'(OVERSAMPLE / 2);
  localparam logic [PhW-1:0]  PhMidP1  = PhW'(OVERSAMPLE / 2 + 1);
  localparam logic [PhW-1:0]  PhLast   = PhW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0] BitLast  = BitW'(DATA_BITS - 1);
  localparam logic            StopLast = (STOP_BITS > 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [DivW-1:0]      div_q;
  logic [PhW-1:0]       ph_q, ph_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 v0_q, v0_d, v1_q, v1_d;
  logic                 par_q, par_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, perr_q, ferr_q, oerr_q;

  logic tick, voted, complete, at_mid_p1, at_last, par_calc, perr_new, ferr_new;

  assign tick      = enable && (div_q == DivLast);
  // Samples at MID-1 and MID are held; the live sample at MID+1 completes the vote.
  assign voted     = (v0_q & v1_q) | (v0_q & rx_s_q) | (v1_q & rx_s_q);
  assign at_mid_p1 = (ph_q == PhMidP1);
  assign at_last   = (ph_q == PhLast);
  assign par_calc  = (^shift_q) ^ par_q;
  assign perr_new  = (PARITY_MODE == 1) ? par_calc :
                     (PARITY_MODE == 2) ? ~par_calc : 1'b0;
  assign ferr_new  = ferr_acc_q | ~voted;

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    bit_d      = bit_q;
    stop_d     = stop_q;
    shift_d    = shift_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    par_d      = par_q;
    ferr_acc_d = ferr_acc_q;
    complete   = 1'b0;
    if (!enable) begin
      state_d = StIdle;
      ph_d    = '0;
    end else if (tick) begin
      ph_d = at_last ? '0 : ph_q + 1'b1;
      if (ph_q == PhMidM1) v0_d = rx_s_q;
      if (ph_q == PhMid)   v1_d = rx_s_q;
      unique case (state_q)
        StIdle: begin
          ph_d = '0;
          if (!rx_s_q) begin
            state_d    = StStart;
            ferr_acc_d = 1'b0;
          end
        end
        StStart: begin
          if (at_mid_p1 && voted) begin
            state_d = StIdle;  // glitch, not a real start bit
          end else if (at_last) begin
            state_d = StData;
            bit_d   = '0;
          end
        end
        StData: begin
          if (at_mid_p1) shift_d = {voted, shift_q[DATA_BITS-1:1]};
          if (at_last) begin
            if (bit_q == BitLast) begin
              state_d = (PARITY_MODE != 0) ? StParity : StStop;
              stop_d  = 1'b0;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
        StParity: begin
          if (at_mid_p1) par_d = voted;
          if (at_last) begin
            state_d = StStop;
            stop_d  = 1'b0;
          end
        end
        StStop: begin
          if (at_mid_p1) begin
            if (!voted) ferr_acc_d = 1'b1;
            // Finish half a bit early so the next start edge is never missed.
            if (stop_q == StopLast) begin
              complete = 1'b1;
              state_d  = StIdle;
            end
          end else if (at_last) begin
            stop_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      div_q      <= '0;
      state_q    <= StIdle;
      ph_q       <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
      shift_q    <= '0;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      par_q      <= 1'b0;
      ferr_acc_q <= 1'b0;
    end else begin
      rx_meta_q  <= rx_in;
      rx_s_q     <= rx_meta_q;
      div_q      <= (!enable || tick) ? '0 : div_q + 1'b1;
      state_q    <= state_d;
      ph_q       <= ph_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      shift_q    <= shift_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      par_q      <= par_d;
      ferr_acc_q <= ferr_acc_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else if (complete) begin
      // A new character beats a same-cycle ack; the ack then counts for the old one.
      data_q  <= shift_q;
      valid_q <= 1'b1;
      perr_q  <= perr_new;
      ferr_q  <= ferr_new;
      oerr_q  <= valid_q & ~rx_bus.rx_ack;
    end else if (rx_bus.rx_ack && valid_q) begin
      valid_q <= 1'b0;
      oerr_q  <= 1'b0;
    end
  end

  assign rx_bus.rx_data     = data_q;
  assign rx_bus.rx_valid    = valid_q;
  assign rx_bus.parity_err  = perr_q;
  assign rx_bus.framing_err = ferr_q;
  assign rx_bus.overrun_err = oerr_q;
  assign busy               = (state_q != StIdle);

endmodule
